dcache_mshr_ctrl: RTL and testbench

Parametrised non-blocking data-cache controller between the LSQ, the direct-mapped dcache array and the memory bus. It serves load hits from the cache, issues load misses and write-through stores to memory, and tracks outstanding loads in a tag-indexed MSHR file of 2**TAG_W-1 entries. It returns fill data to the LSQ with the originating LSQ id, blocks same-address hazards, and supports a pipeline flush that squashes in-flight loads.

---
 rtl/dcache_mshr_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_dcache_mshr_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dcache_mshr_ctrl.sv
// Non-blocking dcache controller: serves load hits, issues misses and write-through
// stores, and tracks outstanding loads in a tag-indexed MSHR file. Optional: DCACHE_MSHR_STATS_EN.
module dcache_mshr_ctrl #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int TAG_W  = 4,
   parameter int ID_W   = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              lsq_req_valid,
   input  logic              lsq_req_is_store,
   input  logic [ADDR_W-1:0] lsq_req_addr,
   input  logic [DATA_W-1:0] lsq_req_data,
   input  logic [ID_W-1:0]   lsq_req_id,
   output logic              lsq_req_ready,
   input  logic              lsq_flush,
   output logic              lsq_resp_valid,
   output logic              lsq_resp_is_store,
   output logic [ID_W-1:0]   lsq_resp_id,
   output logic [DATA_W-1:0] lsq_resp_data,
   output logic [ADDR_W-1:0] cache_rd_addr,
   input  logic [DATA_W-1:0] cache_rd_data,
   input  logic              cache_rd_hit,
   output logic              cache_wr_en,
   output logic [ADDR_W-1:0] cache_wr_addr,
   output logic [DATA_W-1:0] cache_wr_data,
   output logic [1:0]        mem_command,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic [TAG_W-1:0]  mem_response,
   input  logic [TAG_W-1:0]  mem_tag,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_MSHR_STATS_EN
   ,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses,
   output logic [31:0]       stat_stall_cycles
`endif
);
   localparam int NENT = 2 ** TAG_W;
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef enum logic [1:0] {E_FREE = 2'd0, E_PEND = 2'd1, E_SQ = 2'd2} ent_e;

   // Slot 0 exists only so tags index directly; it is never allocated.
   ent_e              state_q [NENT];
   ent_e              state_d [NENT];
   logic [ADDR_W-1:0] addr_q  [NENT];
   logic [ADDR_W-1:0] addr_d  [NENT];
   logic [ID_W-1:0]   id_q    [NENT];
   logic [ID_W-1:0]   id_d    [NENT];

   logic              resp_valid_q, resp_valid_d;
   logic              resp_is_store_q, resp_is_store_d;
   logic [ID_W-1:0]   resp_id_q, resp_id_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;

   logic conflict, fill, req_v, mem_acc, do_hit, do_miss, do_store;

   always_comb begin
      conflict = 1'b0;
      for (int i = 1; i < NENT; i++)
         conflict = conflict | ((state_q[i] != E_FREE) && (addr_q[i] == lsq_req_addr));
   end

   // A flush cycle behaves as if no request were presented.
   assign req_v    = lsq_req_valid & ~lsq_flush;
   assign fill     = (mem_tag != {TAG_W{1'b0}}) && (state_q[mem_tag] != E_FREE);
   assign mem_acc  = (mem_response != {TAG_W{1'b0}});
   assign do_hit   = req_v & ~lsq_req_is_store & cache_rd_hit & ~conflict & ~fill;
   assign do_miss  = req_v & ~lsq_req_is_store & ~cache_rd_hit & ~conflict;
   assign do_store = req_v & lsq_req_is_store & ~conflict & ~fill;

   assign lsq_req_ready = do_hit | ((do_miss | do_store) & mem_acc);
   assign cache_rd_addr = lsq_req_addr;
   assign mem_addr      = lsq_req_addr;
   assign mem_data      = lsq_req_data;

   always_comb begin
      if (do_miss)
         mem_command = BUS_LOAD;
      else if (do_store)
         mem_command = BUS_STORE;
      else
         mem_command = BUS_NONE;
   end

   // Fill owns the cache write port; otherwise an accepted store writes through.
   always_comb begin
      if (fill) begin
         cache_wr_en   = 1'b1;
         cache_wr_addr = addr_q[mem_tag];
         cache_wr_data = mem_rdata;
      end else if (do_store && mem_acc) begin
         cache_wr_en   = 1'b1;
         cache_wr_addr = lsq_req_addr;
         cache_wr_data = lsq_req_data;
      end else begin
         cache_wr_en   = 1'b0;
         cache_wr_addr = {ADDR_W{1'b0}};
         cache_wr_data = {DATA_W{1'b0}};
      end
   end

   // Entry update order: flush squash, then fill free, then allocation wins.
   always_comb begin
      for (int i = 0; i < NENT; i++) begin
         state_d[i] = state_q[i];
         addr_d[i]  = addr_q[i];
         id_d[i]    = id_q[i];
         if (lsq_flush && state_q[i] == E_PEND)
            state_d[i] = E_SQ;
         else
            state_d[i] = state_q[i];
         if (fill && TAG_W'(i) == mem_tag)
            state_d[i] = E_FREE;
         else
            state_d[i] = state_d[i];
         if (do_miss && mem_acc && TAG_W'(i) == mem_response) begin
            state_d[i] = E_PEND;
            addr_d[i]  = lsq_req_addr;
            id_d[i]    = lsq_req_id;
         end else begin
            addr_d[i]  = addr_q[i];
            id_d[i]    = id_q[i];
         end
      end
   end

   always_comb begin
      resp_valid_d    = 1'b0;
      resp_is_store_d = 1'b0;
      resp_id_d       = {ID_W{1'b0}};
      resp_data_d     = {DATA_W{1'b0}};
      if (lsq_flush) begin
         resp_valid_d = 1'b0;
      end else if (fill && state_q[mem_tag] == E_PEND) begin
         resp_valid_d = 1'b1;
         resp_id_d    = id_q[mem_tag];
         resp_data_d  = mem_rdata;
      end else if (do_hit) begin
         resp_valid_d = 1'b1;
         resp_id_d    = lsq_req_id;
         resp_data_d  = cache_rd_data;
      end else if (do_store && mem_acc) begin
         resp_valid_d    = 1'b1;
         resp_is_store_d = 1'b1;
         resp_id_d       = lsq_req_id;
      end else begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NENT; i++) begin
            state_q[i] <= E_FREE;
            addr_q[i]  <= {ADDR_W{1'b0}};
            id_q[i]    <= {ID_W{1'b0}};
         end
         resp_valid_q    <= 1'b0;
         resp_is_store_q <= 1'b0;
         resp_id_q       <= {ID_W{1'b0}};
         resp_data_q     <= {DATA_W{1'b0}};
      end else begin
         for (int i = 0; i < NENT; i++) begin
            state_q[i] <= state_d[i];
            addr_q[i]  <= addr_d[i];
            id_q[i]    <= id_d[i];
         end
         resp_valid_q    <= resp_valid_d;
         resp_is_store_q <= resp_is_store_d;
         resp_id_q       <= resp_id_d;
         resp_data_q     <= resp_data_d;
      end
   end

   assign lsq_resp_valid    = resp_valid_q;
   assign lsq_resp_is_store = resp_is_store_q;
   assign lsq_resp_id       = resp_id_q;
   assign lsq_resp_data     = resp_data_q;

`ifdef DCACHE_MSHR_STATS_EN
   logic [31:0] hits_q, hits_d, misses_q, misses_d, stalls_q, stalls_d;

   // Saturating event counters.
   always_comb begin
      hits_d   = hits_q;
      misses_d = misses_q;
      stalls_d = stalls_q;
      if (do_hit && hits_q != 32'hFFFF_FFFF)
         hits_d = hits_q + 32'd1;
      else
         hits_d = hits_q;
      if (do_miss && mem_acc && misses_q != 32'hFFFF_FFFF)
         misses_d = misses_q + 32'd1;
      else
         misses_d = misses_q;
      if (lsq_req_valid && !lsq_req_ready && stalls_q != 32'hFFFF_FFFF)
         stalls_d = stalls_q + 32'd1;
      else
         stalls_d = stalls_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hits_q   <= 32'd0;
         misses_q <= 32'd0;
         stalls_q <= 32'd0;
      end else begin
         hits_q   <= hits_d;
         misses_q <= misses_d;
         stalls_q <= stalls_d;
      end
   end

   assign stat_hits         = hits_q;
   assign stat_misses       = misses_q;
   assign stat_stall_cycles = stalls_q;
`endif
endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Randomized bench for dcache_mshr_ctrl: the bench plays LSQ, cache array and memory,
// and a table-based reference of outstanding loads predicts every output.
module tb_dcache_mshr_ctrl;
   logic        clock = 1'b0;
   logic        reset;
   logic        lsq_req_valid, lsq_req_is_store, lsq_flush;
   logic [63:0] lsq_req_addr, lsq_req_data;
   logic [4:0]  lsq_req_id;
   logic        lsq_req_ready;
   logic        lsq_resp_valid, lsq_resp_is_store;
   logic [4:0]  lsq_resp_id;
   logic [63:0] lsq_resp_data;
   logic [63:0] cache_rd_addr, cache_rd_data;
   logic        cache_rd_hit;
   logic        cache_wr_en;
   logic [63:0] cache_wr_addr, cache_wr_data;
   logic [1:0]  mem_command;
   logic [63:0] mem_addr, mem_data, mem_rdata;
   logic [3:0]  mem_response, mem_tag;
`ifdef DCACHE_MSHR_STATS_EN
   logic [31:0] stat_hits, stat_misses, stat_stall_cycles;
`endif

   dcache_mshr_ctrl dut (
      .clock(clock), .reset(reset),
      .lsq_req_valid(lsq_req_valid), .lsq_req_is_store(lsq_req_is_store),
      .lsq_req_addr(lsq_req_addr), .lsq_req_data(lsq_req_data), .lsq_req_id(lsq_req_id),
      .lsq_req_ready(lsq_req_ready), .lsq_flush(lsq_flush),
      .lsq_resp_valid(lsq_resp_valid), .lsq_resp_is_store(lsq_resp_is_store),
      .lsq_resp_id(lsq_resp_id), .lsq_resp_data(lsq_resp_data),
      .cache_rd_addr(cache_rd_addr), .cache_rd_data(cache_rd_data), .cache_rd_hit(cache_rd_hit),
      .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
      .mem_command(mem_command), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_response(mem_response), .mem_tag(mem_tag), .mem_rdata(mem_rdata)
`ifdef DCACHE_MSHR_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_stall_cycles(stat_stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: what each memory tag is waiting for (0 = nothing, 1 = live load, 2 = squashed).
   int          ref_wait [16];
   logic [63:0] ref_addr [16];
   logic [4:0]  ref_id   [16];
   logic        exp_rv, exp_rs;
   logic [4:0]  exp_rid;
   logic [63:0] exp_rdata;

   logic [63:0] addr_pool [6];

   task automatic drive_random(input bit force_reset);
      int live [$];
      int free [$];
      for (int t = 1; t < 16; t++)
         if (ref_wait[t] != 0) live.push_back(t); else free.push_back(t);
      reset            = force_reset ? 1'b1 : ($urandom_range(0, 199) == 0);
      lsq_flush        = ($urandom_range(0, 19) == 0);
      lsq_req_valid    = ($urandom_range(0, 9) < 7);
      lsq_req_is_store = ($urandom_range(0, 2) == 0);
      lsq_req_addr     = addr_pool[$urandom_range(0, 5)];
      lsq_req_data     = {$urandom, $urandom};
      lsq_req_id       = 5'($urandom_range(0, 31));
      cache_rd_hit     = $urandom_range(0, 1);
      cache_rd_data    = {$urandom, $urandom};
      mem_rdata        = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0)
         mem_response = 4'd0;
      else if (free.size() > 0 && $urandom_range(0, 4) != 0)
         mem_response = 4'(free[$urandom_range(0, free.size() - 1)]);
      else
         mem_response = 4'($urandom_range(1, 15));
      if (live.size() > 0 && $urandom_range(0, 9) < 4)
         mem_tag = 4'(live[$urandom_range(0, live.size() - 1)]);
      else if ($urandom_range(0, 9) < 2)
         mem_tag = 4'($urandom_range(1, 15));
      else
         mem_tag = 4'd0;
   endtask

   // Decide what the controller should do with this cycle's inputs, check it, then advance.
   task automatic model_step(input bit do_checks);
      bit blocked, filling, accepted;
      string action;
      logic [1:0] cmd;
      blocked = 1'b0;
      for (int t = 1; t < 16; t++)
         if (ref_wait[t] != 0 && ref_addr[t] == lsq_req_addr) blocked = 1'b1;
      filling  = (mem_tag != 4'd0) && (ref_wait[mem_tag] != 0);
      accepted = (mem_response != 4'd0);

      if (!lsq_req_valid || lsq_flush || blocked) action = "idle";
      else if (lsq_req_is_store) action = filling ? "idle" : "store";
      else if (cache_rd_hit) action = filling ? "idle" : "hit";
      else action = "miss";

      cmd = (action == "miss") ? 2'd1 : (action == "store") ? 2'd2 : 2'd0;
      if (do_checks) begin
         check_eq("ready", lsq_req_ready,
                  (action == "hit") || ((action == "miss" || action == "store") && accepted));
         check_eq("mem_command", mem_command, cmd);
         check_eq("cache_rd_addr", cache_rd_addr, lsq_req_addr);
         if (cmd != 2'd0) check_eq("mem_addr", mem_addr, lsq_req_addr);
         if (cmd == 2'd2) check_eq("mem_data", mem_data, lsq_req_data);
         check_eq("cache_wr_en", cache_wr_en, filling || (action == "store" && accepted));
         if (filling) begin
            check_eq("fill_wr_addr", cache_wr_addr, ref_addr[mem_tag]);
            check_eq("fill_wr_data", cache_wr_data, mem_rdata);
         end else if (action == "store" && accepted) begin
            check_eq("st_wr_addr", cache_wr_addr, lsq_req_addr);
            check_eq("st_wr_data", cache_wr_data, lsq_req_data);
         end
      end

      exp_rv = 1'b0; exp_rs = 1'b0; exp_rid = 5'd0; exp_rdata = 64'd0;
      if (!reset && !lsq_flush) begin
         if (filling && ref_wait[mem_tag] == 1) begin
            exp_rv = 1'b1; exp_rid = ref_id[mem_tag]; exp_rdata = mem_rdata;
         end else if (action == "hit") begin
            exp_rv = 1'b1; exp_rid = lsq_req_id; exp_rdata = cache_rd_data;
         end else if (action == "store" && accepted) begin
            exp_rv = 1'b1; exp_rs = 1'b1; exp_rid = lsq_req_id;
         end
      end

      if (reset) begin
         for (int t = 0; t < 16; t++) ref_wait[t] = 0;
      end else begin
         if (lsq_flush)
            for (int t = 1; t < 16; t++) if (ref_wait[t] == 1) ref_wait[t] = 2;
         if (filling) ref_wait[mem_tag] = 0;
         if (action == "miss" && accepted) begin
            ref_wait[mem_response] = 1;
            ref_addr[mem_response] = lsq_req_addr;
            ref_id[mem_response]   = lsq_req_id;
         end
      end
   endtask

   initial begin
      addr_pool[0] = 64'h100; addr_pool[1] = 64'h200; addr_pool[2] = 64'h300;
      addr_pool[3] = 64'h400; addr_pool[4] = 64'hFFFF_0000_0000_0200; addr_pool[5] = 64'h0;
      for (int t = 0; t < 16; t++) begin
         ref_wait[t] = 0; ref_addr[t] = 64'd0; ref_id[t] = 5'd0;
      end
      drive_random(1'b1);
      @(posedge clock);
      #1;
      for (int n = 0; n < 4000; n++) begin
         if (n > 0) begin
            check_eq("resp_valid", lsq_resp_valid, exp_rv);
            if (exp_rv) begin
               check_eq("resp_is_store", lsq_resp_is_store, exp_rs);
               check_eq("resp_id", lsq_resp_id, exp_rid);
               check_eq("resp_data", lsq_resp_data, exp_rdata);
            end
         end
         drive_random(n < 2);
         #1;
         model_step(n > 0);
         @(posedge clock);
         #1;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
